// File: rtl/dram_resp_pkg.sv
// Shared types for the DRAM transaction responder: service FSM states and
// the default address width of a queued request.
package dram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        COMP = 2'd2
    } state_e;

    localparam int DEFAULT_ADDR_W = 64;

endpackage

// File: rtl/tx_req_fifo.sv
// In-order request queue: DEPTH entries with wrap-around pointers and an
// occupancy count. A push while full and a pop while empty are ignored.
module tx_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             push_ok;
    logic             pop_ok;

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = rd_ptr + PTR_W'(1);
    assign head        = mem[rd_ptr];
    // Entry behind the head, needed when completions run back to back.
    assign head_next   = mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr_next;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dram_tx_responder.sv
// Memory-side responder: queues tx_enq requests in order and returns one
// tx_comp pulse per request after a fixed access latency.
module dram_tx_responder
    import dram_resp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 8,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_enq,
    input  logic              is_wr,
    input  logic [ADDR_W-1:0] addr,
    output logic              tx_comp,
    output logic              is_wr_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              full,
    output logic              busy,
    output logic              overflow
);
    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
    } req_t;

    localparam int                REQ_W     = $bits(req_t);
    localparam int                CNT_W     = $clog2(LATENCY);
    localparam int                QCNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 2);
    // With LATENCY of 2 there is no room for a WAIT cycle between completions.
    localparam bit                SKIP_WAIT = (LATENCY == 2);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    req_t              push_req;
    req_t              head_req;
    req_t              head_next_req;
    logic [REQ_W-1:0]  head_bits;
    logic [REQ_W-1:0]  head_next_bits;
    logic [QCNT_W-1:0] count;
    logic              empty;

    assign push_req      = '{is_wr: is_wr, addr: addr};
    assign head_req      = req_t'(head_bits);
    assign head_next_req = req_t'(head_next_bits);

    tx_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_enq),
        .pop       (tx_comp),
        .din       (push_req),
        .head      (head_bits),
        .head_next (head_next_bits),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign tx_comp = (state == COMP);
    assign busy    = !empty || (state != IDLE);

    // Stay-busy decisions use the registered count, so a same-cycle push
    // only takes effect from the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_wr_out <= 1'b0;
            addr_out  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (tx_enq && full) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (SKIP_WAIT) begin
                            state     <= COMP;
                            is_wr_out <= head_req.is_wr;
                            addr_out  <= head_req.addr;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= COMP;
                        is_wr_out <= head_req.is_wr;
                        addr_out  <= head_req.addr;
                    end
                end
                COMP: begin
                    if (count > QCNT_W'(1)) begin
                        if (SKIP_WAIT) begin
                            state     <= COMP;
                            is_wr_out <= head_next_req.is_wr;
                            addr_out  <= head_next_req.addr;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_tx_responder.sv
// Scoreboard bench for dram_tx_responder: LATENCY=8 and LATENCY=2 instances,
// expected completions queued at stimulus time and checked by a monitor.
module tb_dram_tx_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        en1 = 1'b0, w1 = 1'b0;
    logic [63:0] a1 = '0;
    logic        comp1, wo1, full1, busy1, ovf1;
    logic [63:0] ao1;

    logic        en2 = 1'b0, w2 = 1'b0;
    logic [63:0] a2 = '0;
    logic        comp2, wo2, full2, busy2, ovf2;
    logic [63:0] ao2;

    int cyc = 0;
    int base = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          c;
        logic        w;
        logic [63:0] a;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_tx_responder #(.DEPTH(4), .LATENCY(8), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .tx_enq(en1), .is_wr(w1), .addr(a1),
        .tx_comp(comp1), .is_wr_out(wo1), .addr_out(ao1),
        .full(full1), .busy(busy1), .overflow(ovf1)
    );

    dram_tx_responder #(.DEPTH(4), .LATENCY(2), .ADDR_W(64)) dut_l2 (
        .clk(clk), .reset(reset), .tx_enq(en2), .is_wr(w2), .addr(a2),
        .tx_comp(comp2), .is_wr_out(wo2), .addr_out(ao2),
        .full(full2), .busy(busy2), .overflow(ovf2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc - base);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int rel);
        while (cyc - base < rel) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        base = cyc;
        q1.delete();
        q2.delete();
    endtask

    // delta == 0 marks a request that must be dropped or discarded.
    task automatic enq1(input logic wr, input logic [63:0] ad, input int delta);
        en1 = 1'b1; w1 = wr; a1 = ad;
        if (delta > 0) q1.push_back('{cyc + delta, wr, ad});
        tick();
        en1 = 1'b0;
    endtask

    task automatic enq2(input logic wr, input logic [63:0] ad, input int delta);
        en2 = 1'b1; w2 = wr; a2 = ad;
        if (delta > 0) q2.push_back('{cyc + delta, wr, ad});
        tick();
        en2 = 1'b0;
    endtask

    initial begin
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (comp1 === 1'b1) begin
                        if (q1.size() == 0) chk("spurious_comp_l8", comp1, 0);
                        else begin
                            e = q1.pop_front();
                            chk("comp_cycle_l8", cyc, e.c);
                            chk("comp_is_wr_l8", wo1, e.w);
                            chk("comp_addr_l8", ao1, e.a);
                        end
                    end
                    if (comp2 === 1'b1) begin
                        if (q2.size() == 0) chk("spurious_comp_l2", comp2, 0);
                        else begin
                            e = q2.pop_front();
                            chk("comp_cycle_l2", cyc, e.c);
                            chk("comp_is_wr_l2", wo2, e.w);
                            chk("comp_addr_l2", ao2, e.a);
                        end
                    end
                end
            end
        join_none

        // reset state
        do_reset();
        chk("rst_tx_comp", comp1, 0);
        chk("rst_is_wr_out", wo1, 0);
        chk("rst_addr_out", ao1, 0);
        chk("rst_full", full1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_overflow", ovf1, 0);

        // single read: enq cycle 5, comp cycle 13, idle from 14
        go_to(5);
        enq1(1'b0, 64'h1000, 8);
        chk("t1_busy_pending", busy1, 1);
        go_to(13);
        chk("t1_busy_in_comp", busy1, 1);
        go_to(14);
        chk("t1_busy_after", busy1, 0);

        // back-to-back writes: comps 13, 20, 27; enq during last COMP -> 35
        do_reset();
        go_to(5);
        enq1(1'b1, 64'hA0, 8);
        enq1(1'b1, 64'hB0, 14);
        enq1(1'b1, 64'hC0, 20);
        go_to(27);
        enq1(1'b0, 64'hD0, 8);
        go_to(40);
        chk("t2_idle", busy1, 0);

        // overflow: 5th request dropped, 4 completions at 13, 20, 27, 34
        do_reset();
        go_to(5);
        enq1(1'b0, 64'h10, 8);
        enq1(1'b0, 64'h20, 14);
        enq1(1'b0, 64'h30, 20);
        enq1(1'b0, 64'h40, 26);
        chk("t3_full_after_4", full1, 1);
        chk("t3_ovf_before_drop", ovf1, 0);
        enq1(1'b0, 64'h50, 0);
        chk("t3_ovf_set", ovf1, 1);
        go_to(40);
        chk("t3_ovf_held", ovf1, 1);
        chk("t3_full_drained", full1, 0);

        // push while full coinciding with COMP is dropped; count ends at DEPTH-1
        do_reset();
        go_to(5);
        enq1(1'b1, 64'h1, 8);
        enq1(1'b0, 64'h2, 14);
        enq1(1'b1, 64'h3, 20);
        enq1(1'b0, 64'h4, 26);
        go_to(13);
        chk("t4_full_at_comp", full1, 1);
        chk("t4_in_comp", comp1, 1);
        enq1(1'b1, 64'h5, 0);
        chk("t4_full_after_pop", full1, 0);
        chk("t4_ovf", ovf1, 1);
        enq1(1'b0, 64'h6, 27);
        chk("t4_full_again", full1, 1);
        go_to(45);

        // reset mid-operation with two queued requests
        do_reset();
        go_to(5);
        enq1(1'b1, 64'h100, 8);
        enq1(1'b0, 64'h200, 0);
        enq1(1'b1, 64'h300, 0);
        go_to(14);
        chk("t5_addr_before", ao1, 64'h100);
        chk("t5_is_wr_before", wo1, 1);
        go_to(15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_comp", comp1, 0);
        chk("t5_rst_is_wr_out", wo1, 0);
        chk("t5_rst_addr_out", ao1, 0);
        chk("t5_rst_busy", busy1, 0);
        chk("t5_rst_full", full1, 0);
        go_to(20);
        enq1(1'b1, 64'h400, 8);
        go_to(40);

        // LATENCY=2: enq 5 -> comp 7; enqs 10,11,12 -> comps 12,13,14
        do_reset();
        go_to(5);
        enq2(1'b0, 64'h700, 2);
        go_to(10);
        enq2(1'b1, 64'h710, 2);
        enq2(1'b1, 64'h720, 2);
        enq2(1'b0, 64'h730, 2);
        go_to(16);
        chk("t6_idle", busy2, 0);
        chk("t6_ovf", ovf2, 0);

        for (int i = 0; i < 60 && (q1.size() != 0 || q2.size() != 0); i++) tick();
        chk("pending_l8", q1.size(), 0);
        chk("pending_l2", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
